// File: rtl/qpsk_pkg.sv
// Shared constants for the I/Q symbol slicer: modulation modes and the 2-bit
// per-branch decision codes ({sign, inner}).
package qpsk_pkg;

  typedef enum logic {
    MODE_QPSK  = 1'b0,
    MODE_QAM16 = 1'b1
  } mode_e;

  // Decision codes. DEC_NONE shares its encoding with DEC_P3: after reset the
  // outputs read 2'b00 until the first decision is made.
  localparam logic [1:0] DEC_NONE = 2'b00;
  localparam logic [1:0] DEC_P3   = 2'b00;
  localparam logic [1:0] DEC_P1   = 2'b01;
  localparam logic [1:0] DEC_M1   = 2'b11;
  localparam logic [1:0] DEC_M3   = 2'b10;

  // Map a sign bit and an inner/outer flag onto the decision code.
  function automatic logic [1:0] dec_code(input logic neg, input logic inner);
    logic [1:0] code;
    case ({neg, inner})
      2'b00:   code = DEC_P3;
      2'b01:   code = DEC_P1;
      2'b11:   code = DEC_M1;
      default: code = DEC_M3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/decision_slicer.sv
// One-branch hard decision: magnitude with saturation, threshold compare and
// sign, registered together with the sample the decision was made on.
module decision_slicer
  import qpsk_pkg::*;
#(
  parameter int DATA_W = 36
) (
  input  logic              clk_fs,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] x_i,
  input  mode_e             mode_i,
  input  logic [DATA_W-2:0] thresh_i,
  output logic [1:0]        dec_o,
  output logic [DATA_W-1:0] sample_o
);

  localparam logic [DATA_W-2:0] MAG_MAX = '1;
  localparam logic [DATA_W-2:0] MAG_ONE = (DATA_W-1)'(1);

  logic              neg;
  logic [DATA_W-2:0] neg_low;
  logic [DATA_W-2:0] mag;
  logic              inner;
  logic [1:0]        dec_d;
  logic [1:0]        dec_q;
  logic [DATA_W-1:0] sample_q;

  // Combinational slice: |x| in DATA_W-1 bits, most-negative input saturates.
  always_comb begin
    neg     = x_i[DATA_W-1];
    neg_low = ~x_i[DATA_W-2:0] + MAG_ONE;
    mag     = x_i[DATA_W-2:0];
    if (neg) begin
      // Sign set with all-zero low bits is -2^(DATA_W-1); its magnitude
      // does not fit, so clip to the largest representable value.
      if (x_i[DATA_W-2:0] == '0) begin
        mag = MAG_MAX;
      end else begin
        mag = neg_low;
      end
    end
    inner = (mode_i == MODE_QAM16) ? (mag < thresh_i) : 1'b1;
    dec_d = dec_code(neg, inner);
  end

  // Output register: holds the last decision until a new one arrives.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      dec_q    <= DEC_NONE;
      sample_q <= '0;
    end else if (valid_i) begin
      dec_q    <= dec_d;
      sample_q <= x_i;
    end
  end

  assign dec_o    = dec_q;
  assign sample_o = sample_q;

endmodule

// File: rtl/symbol_decision.sv
// I/Q symbol decision stage: counts samples within a symbol, picks the sample
// at a programmable phase, and slices both branches (QPSK or 16-QAM) with a
// two-register pipeline ending in a one-cycle sym_valid strobe.
module symbol_decision
  import qpsk_pkg::*;
#(
  parameter int   DATA_W = 36,
  parameter int   SPS    = 4,
  localparam int  CNT_W  = $clog2(SPS)
) (
  input  logic              clk_fs,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] filter_in_I,
  input  logic [DATA_W-1:0] filter_in_Q,
  input  logic [CNT_W-1:0]  phase_sel,
  input  logic              cnt_clr,
  input  logic              mode,
  input  logic [DATA_W-2:0] thresh,
  output logic              sym_valid,
  output logic [1:0]        bit_out_I,
  output logic [1:0]        bit_out_Q,
  output logic [DATA_W-1:0] temp_I,
  output logic [DATA_W-1:0] temp_Q
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);

  // Sample counter and shadowed symbol configuration
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  mode_e             mode_q, mode_d;

  // Stage-1 capture of the selected sample
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_i_q;
  logic [DATA_W-1:0] s1_q_q;
  mode_e             s1_mode_q;

  logic              sym_valid_q;

  // Per-cycle decode
  logic              at_idx0;
  logic [CNT_W-1:0]  idx_cur;
  logic [CNT_W-1:0]  phase_clamped;
  logic [CNT_W-1:0]  phase_eff;
  mode_e             mode_eff;

  // Index of the current cycle, effective phase/mode and the next counter value.
  always_comb begin
    at_idx0       = cnt_clr || (cnt_q == '0);
    idx_cur       = cnt_clr ? '0 : cnt_q;
    phase_clamped = (phase_sel > LAST_IDX) ? LAST_IDX : phase_sel;
    // At index 0 the new configuration is picked up directly, so a phase of 0
    // already applies to the index-0 sample; elsewhere the shadow copy rules.
    phase_eff     = at_idx0 ? phase_clamped : phase_q;
    mode_eff      = at_idx0 ? mode_e'(mode) : mode_q;
    phase_d       = phase_eff;
    mode_d        = mode_eff;

    cnt_d = cnt_q;
    if (cnt_clr) begin
      // Realign wins over wrap/increment: a valid sample here is index 0.
      cnt_d = in_valid ? ONE_IDX : '0;
    end else if (in_valid) begin
      cnt_d = (cnt_q >= LAST_IDX) ? '0 : cnt_q + ONE_IDX;
    end

    s1_valid_d = in_valid && (idx_cur == phase_eff);
  end

  // Counter and shadow configuration registers.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
      mode_q  <= MODE_QPSK;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
    end
  end

  // Stage 1: capture the selected I/Q sample with the mode it is sliced in.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
      s1_mode_q  <= MODE_QPSK;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_valid_d) begin
        s1_i_q    <= filter_in_I;
        s1_q_q    <= filter_in_Q;
        s1_mode_q <= mode_eff;
      end
    end
  end

  // Stage 2 strobe, aligned with the slicer output registers.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      sym_valid_q <= 1'b0;
    end else begin
      sym_valid_q <= s1_valid_q;
    end
  end

  decision_slicer #(
    .DATA_W (DATA_W)
  ) u_slicer_i (
    .clk_fs   (clk_fs),
    .rst_n    (rst_n),
    .valid_i  (s1_valid_q),
    .x_i      (s1_i_q),
    .mode_i   (s1_mode_q),
    .thresh_i (thresh),
    .dec_o    (bit_out_I),
    .sample_o (temp_I)
  );

  decision_slicer #(
    .DATA_W (DATA_W)
  ) u_slicer_q (
    .clk_fs   (clk_fs),
    .rst_n    (rst_n),
    .valid_i  (s1_valid_q),
    .x_i      (s1_q_q),
    .mode_i   (s1_mode_q),
    .thresh_i (thresh),
    .dec_o    (bit_out_Q),
    .sample_o (temp_Q)
  );

  assign sym_valid = sym_valid_q;

endmodule
